sweep_array: RTL

SWEEP_ARRAY -- requirements
Module: sweep_array

---
 rtl/sweep_array_pkg.sv | 20 ++
 rtl/sweep_array.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sweep_array_pkg.sv
// Shared types and helpers for the sweep_array register file:
// sweep FSM state encoding and the byte-level write merge.
package sweep_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // One byte lane of a masked write: new byte when enabled, else keep the old one.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sweep_array.sv
// Flip-flop register file with byte-masked writes, multi-port combinational reads
// with write forwarding, and a flush sweep that invalidates one entry per cycle.
module sweep_array #(
    parameter int s_index    = 3,
    parameter int width      = 32,
    parameter int num_rports = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [s_index-1:0]            windex,
    input  logic [width/8-1:0]            wmask,
    input  logic [width-1:0]              datain,
    input  logic [num_rports*s_index-1:0] rindex,
    output logic [num_rports*width-1:0]   dataout,
    output logic [num_rports-1:0]         validout,
    input  logic                          flush,
    output logic                          busy,
    output logic                          done
);
    import sweep_array_pkg::*;

    localparam int num_sets = 2 ** s_index;
    localparam int nbytes   = width / 8;

    logic [width-1:0]    data_r [num_sets];
    logic [num_sets-1:0] valid_r;
    logic [s_index-1:0]  ptr_r;
    sweep_state_t        state_r;
    sweep_state_t        state_s;
    logic                wr_en_s;
    logic                last_s;
    logic [width-1:0]    wmerge_s;
    logic [s_index-1:0]  ridx_s;

    // Writes are only accepted while no sweep is running.
    assign wr_en_s = load && (state_r == IDLE);
    assign last_s  = &ptr_r;

    // Byte-merge of the incoming write over the currently stored entry.
    always_comb begin
        wmerge_s = data_r[windex];
        for (int b = 0; b < nbytes; b++) begin
            wmerge_s[8*b +: 8] = merge_byte(data_r[windex][8*b +: 8], datain[8*b +: 8], wmask[b]);
        end
    end

    // Read ports: forward the in-flight write when it hits the same index.
    always_comb begin
        dataout  = '0;
        validout = '0;
        ridx_s   = '0;
        for (int p = 0; p < num_rports; p++) begin
            ridx_s = rindex[p*s_index +: s_index];
            if (wr_en_s && (ridx_s == windex)) begin
                dataout[p*width +: width] = wmerge_s;
                validout[p]               = 1'b1;
            end else begin
                dataout[p*width +: width] = data_r[ridx_s];
                validout[p]               = valid_r[ridx_s];
            end
        end
    end

    // Entry storage: writes set valid, the sweep clears valid and leaves data alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < num_sets; i++) begin
                data_r[i] <= '0;
            end
            valid_r <= '0;
        end else if (wr_en_s) begin
            data_r[windex]  <= wmerge_s;
            valid_r[windex] <= 1'b1;
        end else if (state_r == SWEEP) begin
            valid_r[ptr_r] <= 1'b0;
        end
    end

    // Sweep pointer: restarts at zero on flush, wraps naturally after the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if ((state_r == IDLE) && flush) begin
            ptr_r <= '0;
        end else if (state_r == SWEEP) begin
            ptr_r <= ptr_r + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; flush is only honoured from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) state_s = SWEEP;
                else       state_s = IDLE;
            end
            SWEEP: begin
                if (last_s) state_s = DONE;
                else        state_s = SWEEP;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            SWEEP: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

endmodule
